// File: rtl/dff_bank_wr_sched.sv
// -----------------------------------------------------------------------------
// dff_bank_wr_sched
//
// Write scheduler for a bank of N gate-level dff registers, each W bits wide.
// Two requesters share the bank's single write data bus. A round-robin arbiter
// picks a winner in IDLE, the winner's address and data are latched, and the
// scheduler then runs a SETUP / STROBE / HOLD sequence on that register's
// clock line. D is stable for a full cycle before C rises, and for a full
// cycle after C falls. The bank's read path (Q/nQ) does not pass through here.
//
// Ports:
//   C              clock, all state updates on the rising edge
//   R              synchronous reset, active-high
//   req0/addr0/wdata0, ack0   requester 0 (req held until ack)
//   req1/addr1/wdata1, ack1   requester 1
//   bank_D  [W-1:0]  shared data bus to every bank register's D input
//   bank_C  [N-1:0]  per-register clock strobes, at most one bit high
//   busy            high in every non-IDLE state
//   owner           current or most recently granted requester
//
// All outputs are registered. One transaction takes 4 cycles; request-to-ack
// latency is 3 cycles.
// -----------------------------------------------------------------------------
module dff_bank_wr_sched #(
  parameter int W  = 8,
  parameter int N  = 4,
  parameter int AW = 2
) (
  input  logic          C,
  input  logic          R,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic [W-1:0]  wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic [W-1:0]  wdata1,
  output logic          ack1,
  output logic [W-1:0]  bank_D,
  output logic [N-1:0]  bank_C,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [AW-1:0]   a_lat, a_lat_n;
  logic [W-1:0]    bank_d_n;
  logic [N-1:0]    bank_c_n;
  logic            ack0_n, ack1_n;
  logic            busy_n;
  logic            owner_n;
  logic            winner;
  logic [N-1:0]    strobe_mask;

  // One-hot decode of the latched address. An address at or beyond N matches
  // no bit, so the transaction still sequences and acks but writes nothing.
  always_comb begin
    strobe_mask = '0;
    for (int i = 0; i < N; i++) begin
      if (a_lat == AW'(i)) strobe_mask[i] = 1'b1;
    end
  end

  // Round-robin pick: a lone request wins outright; under contention the
  // requester that did not own the bus last time wins, giving strict
  // alternation. Only consulted in IDLE.
  always_comb begin
    if (req0 && req1) winner = ~owner;
    else              winner = req1;
  end

  // Next-state and next-output logic.
  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_n  = state;
    a_lat_n  = a_lat;
    bank_d_n = bank_D;   // data bus holds its value until the next grant
    bank_c_n = '0;       // strobe is high for exactly one cycle
    ack0_n   = 1'b0;     // acks are single-cycle pulses
    ack1_n   = 1'b0;
    owner_n  = owner;

    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          owner_n  = winner;
          a_lat_n  = winner ? addr1  : addr0;
          bank_d_n = winner ? wdata1 : wdata0;
          state_n  = SETUP;
        end
      end
      SETUP: begin
        bank_c_n = strobe_mask;
        state_n  = STROBE;
      end
      STROBE: begin
        ack0_n  = (owner == 1'b0);
        ack1_n  = (owner == 1'b1);
        state_n = HOLD;
      end
      HOLD: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  // State and output registers. Reset cuts any in-flight strobe and
  // suppresses the ack of the aborted transaction, since both are simply
  // forced back to their idle values on the reset edge.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge C) begin
    if (R) begin
      state  <= IDLE;
      a_lat  <= '0;
      bank_D <= '0;
      bank_C <= '0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      busy   <= 1'b0;
      owner  <= 1'b1;   // makes requester 0 win the first tie
    end else begin
      state  <= state_n;
      a_lat  <= a_lat_n;
      bank_D <= bank_d_n;
      bank_C <= bank_c_n;
      ack0   <= ack0_n;
      ack1   <= ack1_n;
      busy   <= busy_n;
      owner  <= owner_n;
    end
  end

endmodule

// File: tb/tb_dff_bank_wr_sched.sv
// -----------------------------------------------------------------------------
// tb_dff_bank_wr_sched
//
// Directed bench for dff_bank_wr_sched. A behavioural dff bank captures
// bank_D on each rising bank_C bit so written values can be checked. A second
// instance with N=3 exercises the out-of-range address path.
// -----------------------------------------------------------------------------
module tb_dff_bank_wr_sched;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int AW = 2;

  logic          C;
  logic          R;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic [W-1:0]  wdata0, wdata1;
  logic          ack0, ack1;
  logic [W-1:0]  bank_D;
  logic [N-1:0]  bank_C;
  logic          busy, owner;

  // Second instance, N=3
  logic          req0_b;
  logic [AW-1:0] addr0_b;
  logic [W-1:0]  wdata0_b;
  logic          ack0_b, ack1_b;
  logic [W-1:0]  bank_D_b;
  logic [2:0]    bank_C_b;
  logic          busy_b, owner_b;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the bank registers (positive-edge dff per strobe).
  logic [W-1:0] reg_q [N];

  dff_bank_wr_sched #(.W(W), .N(N), .AW(AW)) u_dut (
    .C      (C),
    .R      (R),
    .req0   (req0),
    .addr0  (addr0),
    .wdata0 (wdata0),
    .ack0   (ack0),
    .req1   (req1),
    .addr1  (addr1),
    .wdata1 (wdata1),
    .ack1   (ack1),
    .bank_D (bank_D),
    .bank_C (bank_C),
    .busy   (busy),
    .owner  (owner)
  );

  dff_bank_wr_sched #(.W(W), .N(3), .AW(AW)) u_dut3 (
    .C      (C),
    .R      (R),
    .req0   (req0_b),
    .addr0  (addr0_b),
    .wdata0 (wdata0_b),
    .ack0   (ack0_b),
    .req1   (1'b0),
    .addr1  (2'd0),
    .wdata1 (8'h00),
    .ack1   (ack1_b),
    .bank_D (bank_D_b),
    .bank_C (bank_C_b),
    .busy   (busy_b),
    .owner  (owner_b)
  );

  for (genvar g = 0; g < N; g++) begin : g_bank
    initial reg_q[g] = '0;
    always @(posedge bank_C[g]) reg_q[g] = bank_D;
  end

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock edge and settle past it.
  task automatic tick();
    @(posedge C);
    #1;
  endtask

  initial begin
    R = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    req0_b = 1'b0; addr0_b = '0; wdata0_b = '0;

    // ---- Reset with both requests asserted ----
    tick();
    check("rst1_bank_C", bank_C, 0);
    tick();
    check("rst_bank_D", bank_D, 0);
    check("rst_bank_C", bank_C, 0);
    check("rst_ack0",   ack0,   0);
    check("rst_ack1",   ack1,   0);
    check("rst_busy",   busy,   0);
    check("rst_owner",  owner,  1);
    check("rst_b_busy", busy_b, 0);
    req0 = 1'b0; req1 = 1'b0;
    R = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // ---- Single write: requester 0 -> register 2 ----
    req0 = 1'b1; addr0 = 2'd2; wdata0 = 8'hA5;
    tick();                                    // grant edge k
    check("sw_setup_busy",   busy,   1);
    check("sw_setup_bank_D", bank_D, 8'hA5);
    check("sw_setup_bank_C", bank_C, 0);
    check("sw_owner",        owner,  0);
    tick();
    check("sw_strobe_bank_C", bank_C, 4'b0100);
    check("sw_strobe_ack0",   ack0,   0);
    tick();
    check("sw_hold_bank_C", bank_C, 0);
    check("sw_hold_ack0",   ack0,   1);
    check("sw_hold_ack1",   ack1,   0);
    check("sw_hold_bank_D", bank_D, 8'hA5);
    req0 = 1'b0;
    tick();
    check("sw_idle_ack0", ack0,   0);
    check("sw_idle_busy", busy,   0);
    check("sw_reg2",      reg_q[2], 8'hA5);
    tick();
    check("sw_idle_bank_D_kept", bank_D, 8'hA5);

    // ---- Latch check: requester 1 data changed during SETUP ----
    req1 = 1'b1; addr1 = 2'd1; wdata1 = 8'h3C;
    tick();
    check("lat_owner",  owner,  1);
    check("lat_bank_D", bank_D, 8'h3C);
    wdata1 = 8'hFF; addr1 = 2'd0;
    tick();
    check("lat_bank_C", bank_C, 4'b0010);
    check("lat_bank_D_stable", bank_D, 8'h3C);
    tick();
    check("lat_ack1", ack1, 1);
    req1 = 1'b0;
    tick();
    check("lat_reg1", reg_q[1], 8'h3C);
    check("lat_reg0_untouched", reg_q[0], 8'h00);

    // ---- Contention: expect grants 0,1,0,1 ----
    req0 = 1'b1; addr0 = 2'd0; wdata0 = 8'h11;
    req1 = 1'b1; addr1 = 2'd3; wdata1 = 8'h22;
    for (int t = 0; t < 4; t++) begin
      logic exp_own;
      exp_own = t[0];
      tick();
      check("ct_owner",  owner,  {31'd0, exp_own});
      check("ct_bank_D", bank_D, exp_own ? 8'h22 : 8'h11);
      tick();
      check("ct_bank_C", bank_C, exp_own ? 4'b1000 : 4'b0001);
      tick();
      check("ct_ack0", ack0, {31'd0, ~exp_own});
      check("ct_ack1", ack1, {31'd0, exp_own});
      check("ct_hold_bank_C", bank_C, 0);
      tick();
      check("ct_idle_busy", busy, 0);
    end
    req0 = 1'b0; req1 = 1'b0;
    check("ct_reg0", reg_q[0], 8'h11);
    check("ct_reg3", reg_q[3], 8'h22);
    check("ct_reg2_kept", reg_q[2], 8'hA5);
    tick();

    // ---- Reset during STROBE ----
    req1 = 1'b1; addr1 = 2'd1; wdata1 = 8'h5A;
    tick();
    tick();
    check("rs_strobe_bank_C", bank_C, 4'b0010);
    R = 1'b1; req1 = 1'b0;
    tick();
    check("rs_bank_C", bank_C, 0);
    check("rs_ack1",   ack1,   0);
    check("rs_ack0",   ack0,   0);
    check("rs_busy",   busy,   0);
    check("rs_owner",  owner,  1);
    check("rs_bank_D", bank_D, 0);
    R = 1'b0;
    tick();
    check("rs_after_bank_C", bank_C, 0);
    check("rs_after_ack1",   ack1,   0);
    req1 = 1'b1; addr1 = 2'd1; wdata1 = 8'h77;
    tick();
    check("rs_new_owner", owner, 1);
    tick();
    check("rs_new_bank_C", bank_C, 4'b0010);
    tick();
    check("rs_new_ack1", ack1, 1);
    req1 = 1'b0;
    tick();
    check("rs_new_reg1", reg_q[1], 8'h77);

    // ---- Out of range on the N=3 instance ----
    req0_b = 1'b1; addr0_b = 2'd3; wdata0_b = 8'h99;
    tick();
    check("oor_busy",   busy_b,   1);
    check("oor_bank_C_setup", bank_C_b, 0);
    check("oor_bank_D", bank_D_b, 8'h99);
    tick();
    check("oor_bank_C_strobe", bank_C_b, 0);
    check("oor_ack0_early", ack0_b, 0);
    tick();
    check("oor_ack0", ack0_b, 1);
    check("oor_bank_C_hold", bank_C_b, 0);
    check("oor_owner", owner_b, 0);
    check("oor_ack1", ack1_b, 0);
    req0_b = 1'b0;
    tick();
    check("oor_ack0_done", ack0_b, 0);
    check("oor_idle_busy", busy_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
